stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Sequencing controller for the stopwatch's 0–59 seconds counter. It owns the run/pause/clear state machine and the one-second prescaler that produces the counter's single-cycle `enable` strobe. It also keeps the minutes count, incremented from the counter's `done` output. It sits between the debounced button pulses and the seconds counter; the display path reads the counter's `seconds` and this block's `minutes`.

## Interface
Clock `clk`; reset `rst`, asynchronous, active-high.

Parameters:
- `TICKS_PER_SEC`, default 50_000_000: `clk` cycles per second. Must be ≥ 2.
- `MAX_MIN`, default 99: highest minutes value. Must be ≤ 127.

Ports:
- `clk` in 1: clock.
- `rst` in 1: async active-high reset.
- `start` in 1: one-cycle pulse; run or resume.
- `stop` in 1: one-cycle pulse; pause.
- `clear` in 1: one-cycle pulse; zero everything and go to IDLE.
- `sec_done` in 1: seconds counter `done` (seconds==59 && enable).
- `sec_en` out 1: enable strobe to the seconds counter.
- `sec_clear` out 1: clear to the seconds counter.
- `minutes` out 7: elapsed minutes, 0..MAX_MIN.
- `running` out 1: state==RUN.
- `overflow` out 1: state==OVF.

## Operation
- States:
  - IDLE: reset state; all counts zero.
  - RUN: prescaler counting.
  - PAUSE: prescaler and minutes frozen.
  - OVF: count exhausted.
- Input priority when pulses coincide: `clear` > `stop` > `start`.
- Transitions:
  - IDLE -start-> RUN.
  - RUN -stop-> PAUSE.
  - PAUSE -start-> RUN.
  - any state -clear-> IDLE.
  - RUN -(minute rollover at MAX_MIN)-> OVF.
  - `start` in RUN or OVF is ignored; `stop` in IDLE, PAUSE or OVF is ignored.
- Prescaler: `pre_cnt`, width $clog2(TICKS_PER_SEC).
  - Counts 0..TICKS_PER_SEC-1 only in RUN.
  - Wraps to 0 after TICKS_PER_SEC-1.
  - Holds its value in PAUSE, so a resumed second completes its remaining fraction.
  - Zeroed in IDLE and OVF.
- `sec_en` = (state==RUN) && (pre_cnt==TICKS_PER_SEC-1). It is combinational, so it is high in the same cycle the counter samples it.
- Minute increment: in a cycle with `sec_en && sec_done`, `minutes` <= `minutes`+1.
- At `minutes`==MAX_MIN with `sec_en && sec_done`:
  - `minutes` holds MAX_MIN; the state goes to OVF.
  - The seconds counter wraps itself to 0, so the displayed value is MAX_MIN:00 with `overflow`=1.
- `sec_clear` is high for exactly the cycle in which `clear` is sampled high, in any state. It is not driven by `rst`; the counter has its own reset.
- `sec_done` is used only when `sec_en` is high; `sec_done` without `sec_en` is ignored.

## Timing
- Reset values: state IDLE, `pre_cnt`=0, `minutes`=0, `sec_en`=0, `sec_clear`=0, `running`=0, `overflow`=0.
- Reset mid-run returns to these values immediately (asynchronous assert); no partial state survives.
- `start` sampled at edge N:
  - `running`=1 after edge N.
  - First `sec_en` is high during cycle N+TICKS_PER_SEC, i.e. TICKS_PER_SEC cycles after the edge.
  - Thereafter `sec_en` repeats every TICKS_PER_SEC cycles.
- `stop` sampled in the same cycle as `sec_en`: the strobe still counts, because `sec_en` is decoded from the current state. The transition takes effect after that edge.
- `clear` coincident with `sec_en`: `sec_en` still pulses, but the counter gives `clear` priority. `minutes` goes to 0, not +1.
- `minutes` and state are registered; they update on the edge that samples the event.

## Configuration
Macro `STOPWATCH_LAP_EN`.
- Defined, adds:
  - Input `lap` (one-cycle pulse).
  - Input `sec_value[5:0]` (the counter's `seconds`).
  - Outputs `lap_min[6:0]`, `lap_sec[5:0]`, `lap_valid`.
- On `lap` in RUN or PAUSE:
  - Capture {`minutes`, `sec_value`}.
  - `lap_valid`<=1.
  - If a minute increment occurs in the same cycle, the pre-increment values are captured.
- `clear` or `rst` zeroes the lap registers and `lap_valid`.
- `lap` in IDLE or OVF is ignored.
- Not defined: these ports and registers do not exist, and behaviour is otherwise identical.

## Structure
- Shared package `stopwatch_pkg`:
  - State enum/localparams ST_IDLE, ST_RUN, ST_PAUSE, ST_OVF (2-bit encoding).
  - `MIN_W`=7 and `SEC_W`=6 width constants.
- One sub-module: `sec_prescaler`, containing the `pre_cnt` counter and terminal-count decode. Its inputs are `run`, `hold` and `zero`; its output is `tick`.
- The FSM and minutes register stay in `stopwatch_ctrl`.

## Test plan
All scenarios use TICKS_PER_SEC=4, MAX_MIN=2, with the seconds counter instantiated alongside.
- Reset, then `start`: `sec_en` pulses every 4 cycles; after 240 cycles `minutes`=1 and seconds=0.
- `stop` at pre_cnt=2, wait 10 cycles, then `start`: no `sec_en` while paused; the next `sec_en` comes 2 cycles after resume.
- Run to 2:59 and let the next `sec_en` fire: `overflow`=1, `running`=0, `minutes`=2, seconds=0; a later `start` is ignored.
- `clear` in the same cycle as `start` from PAUSE: state IDLE, `minutes`=0, `sec_clear` high for 1 cycle.
- `rst` asserted mid-RUN at 1:30: all outputs return to reset values without waiting for a clock edge; a following `start` counts from 0:00.
- With `STOPWATCH_LAP_EN`: `lap` at 0:59 coinciding with the minute rollover gives `lap_min`=0, `lap_sec`=59, `lap_valid`=1, and `minutes` becomes 1.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control path: FSM state encoding
// and the display field widths used by the minutes/seconds registers.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVF   = 2'd3
    } state_t;

    localparam int MIN_W = 7;
    localparam int SEC_W = 6;

endpackage

// File: rtl/sec_prescaler.sv
// One-second prescaler: counts clk cycles while running, freezes while
// held, and decodes the terminal count into a single-cycle tick.
module sec_prescaler #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic hold,
    input  logic zero,
    output logic tick
);

    localparam int                CNT_W = $clog2(TICKS_PER_SEC);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] r_pre_cnt;

    // Prescaler counter: zero wins, then hold keeps a partial second, run counts and wraps.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_pre_cnt <= '0;
        end else if (zero) begin
            r_pre_cnt <= '0;
        end else if (hold) begin
            r_pre_cnt <= r_pre_cnt;
        end else if (run) begin
            r_pre_cnt <= (r_pre_cnt == LAST) ? '0 : r_pre_cnt + 1'b1;
        end
    end

    // Terminal-count decode; combinational so the seconds counter sees it in the same cycle.
    always_comb begin
        tick = run && (r_pre_cnt == LAST);
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: run/pause/clear FSM, minutes register
// and the enable/clear strobes for the external 0-59 seconds counter.
// Optional lap capture is compiled in with `define STOPWATCH_LAP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int MAX_MIN       = 99
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             sec_done,
`ifdef STOPWATCH_LAP_EN
    input  logic             lap,
    input  logic [SEC_W-1:0] sec_value,
    output logic [MIN_W-1:0] lap_min,
    output logic [SEC_W-1:0] lap_sec,
    output logic             lap_valid,
`endif
    output logic             sec_en,
    output logic             sec_clear,
    output logic [MIN_W-1:0] minutes,
    output logic             running,
    output logic             overflow
);

    localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [MIN_W-1:0] r_minutes;
    logic             w_tick;
    logic             w_pre_zero;
    logic             w_sec_step;
    logic             w_min_last;

    // A counted second that is also the 59th second of a minute.
    assign w_sec_step = w_tick && sec_done;
    assign w_min_last = (r_minutes == MAX_MIN_V);
    // Clear zeroes the prescaler on its own edge so an immediate start begins a full second.
    assign w_pre_zero = clear || (r_state == ST_IDLE) || (r_state == ST_OVF);

    sec_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .run (r_state == ST_RUN),
        .hold(r_state == ST_PAUSE),
        .zero(w_pre_zero),
        .tick(w_tick)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic with clear > stop > start priority.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_state_nxt unassigned (no latch).
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:  if (start && !stop) w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (w_sec_step && w_min_last) w_state_nxt = ST_OVF;
                    else if (stop)                w_state_nxt = ST_PAUSE;
                end
                ST_PAUSE: if (start && !stop) w_state_nxt = ST_RUN;
                ST_OVF:   w_state_nxt = ST_OVF;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from the current state and inputs.
    always_comb begin
        sec_en    = w_tick;
        sec_clear = clear;
        running   = (r_state == ST_RUN);
        overflow  = (r_state == ST_OVF);
        minutes   = r_minutes;
    end

    // Minutes register: cleared by clear, bumped on the 59->0 second, saturates at MAX_MIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_minutes <= '0;
        end else if (clear) begin
            r_minutes <= '0;
        end else if (w_sec_step && !w_min_last) begin
            r_minutes <= r_minutes + 1'b1;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [MIN_W-1:0] r_lap_min;
    logic [SEC_W-1:0] r_lap_sec;
    logic             r_lap_valid;

    // Lap capture in RUN/PAUSE; r_minutes is still the pre-increment value on a rollover edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lap_min   <= '0;
            r_lap_sec   <= '0;
            r_lap_valid <= 1'b0;
        end else if (clear) begin
            r_lap_min   <= '0;
            r_lap_sec   <= '0;
            r_lap_valid <= 1'b0;
        end else if (lap && ((r_state == ST_RUN) || (r_state == ST_PAUSE))) begin
            r_lap_min   <= r_minutes;
            r_lap_sec   <= sec_value;
            r_lap_valid <= 1'b1;
        end
    end

    assign lap_min   = r_lap_min;
    assign lap_sec   = r_lap_sec;
    assign lap_valid = r_lap_valid;
`endif

endmodule
